// File: rtl/uart_tx_queue.sv
// Byte FIFO plus drain sequencer that feeds uart_tx one frame at a time over the
// send_trig/send_data/tx_bsy handshake, with post-frame gap and trigger retry.
module uart_tx_queue #(
    parameter int DEPTH_BITS   = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TRIG_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count,
    output logic                  overflow,
    output logic                  idle,
    output logic                  send_trig,
    output logic [7:0]            send_data,
    input  logic                  tx_bsy,
    output logic [15:0]           bytes_sent,
    output logic [7:0]            retries
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CW    = DEPTH_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic [7:0]            r_rd_data;
    logic                  r_send_trig;
    logic [7:0]            r_send_data;
    logic [15:0]           r_bytes_sent;
    logic [7:0]            r_retries;
    logic [15:0]           r_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_trig;
    logic                  w_retry;
    logic                  w_done;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;

    // Full comes from the registered count, so a same-cycle pop never makes room.
    assign w_push = wr_en & ~r_full & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: each always_comb assigns defaults first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if ((r_count != '0) && !flush) w_state_nxt = S_LOAD;
            S_LOAD:    if (!tx_bsy) w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (tx_bsy) w_state_nxt = S_WAIT_LO;
            S_WAIT_LO: if (!tx_bsy) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:     if (r_cnt == 16'(GAP_CYCLES - 1)) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_trig    = 1'b0;
        w_retry   = 1'b0;
        w_done    = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            S_IDLE: w_pop = (r_count != '0) & ~flush;
            S_LOAD: begin
                w_load = 1'b1;
                if (!tx_bsy) begin
                    w_trig    = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (!tx_bsy) begin
                    if (r_cnt == 16'(TRIG_TIMEOUT - 1)) begin
                        w_trig    = 1'b1;
                        w_retry   = 1'b1;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_WAIT_LO: begin
                if (!tx_bsy) begin
                    w_done    = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            S_GAP:   w_cnt_inc = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (flush)                w_count_nxt = '0;
        else if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
        else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
            end
            if (wr_en && r_full && !flush) r_overflow <= 1'b1;
        end
    end

    // NOTE: storage is not reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
        if (w_pop)  r_rd_data <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_send_trig  <= 1'b0;
            r_send_data  <= 8'h00;
            r_cnt        <= '0;
            r_bytes_sent <= '0;
            r_retries    <= '0;
        end else begin
            r_send_trig <= w_trig;
            if (w_load) r_send_data <= r_rd_data;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 16'd1;
            if (w_done) r_bytes_sent <= r_bytes_sent + 16'd1;
            if (w_retry && (r_retries != 8'hFF)) r_retries <= r_retries + 8'd1;
        end
    end

    assign full       = r_full;
    assign empty      = r_empty;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign idle       = r_empty & (r_state == S_IDLE);
    assign send_trig  = r_send_trig;
    assign send_data  = r_send_data;
    assign bytes_sent = r_bytes_sent;
    assign retries    = r_retries;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a behavioural uart_tx model consumes triggers and
// checks each captured byte against a scoreboard filled as bytes are pushed.
module tb_uart_tx_queue;

    localparam int DEPTH_BITS   = 4;
    localparam int GAP_CYCLES   = 2;
    localparam int TRIG_TIMEOUT = 8;

    logic                clk     = 1'b0;
    logic                rst     = 1'b1;
    logic                wr_en   = 1'b0;
    logic [7:0]          wr_data = 8'h00;
    logic                flush   = 1'b0;
    logic                tx_bsy  = 1'b0;
    logic                full;
    logic                empty;
    logic [DEPTH_BITS:0] count;
    logic                overflow;
    logic                idle;
    logic                send_trig;
    logic [7:0]          send_data;
    logic [15:0]         bytes_sent;
    logic [7:0]          retries;

    uart_tx_queue #(
        .DEPTH_BITS  (DEPTH_BITS),
        .GAP_CYCLES  (GAP_CYCLES),
        .TRIG_TIMEOUT(TRIG_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .idle      (idle),
        .send_trig (send_trig),
        .send_data (send_data),
        .tx_bsy    (tx_bsy),
        .bytes_sent(bytes_sent),
        .retries   (retries)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    // uart_tx model knobs, set by the tests
    int busy_len   = 91;
    bit stall      = 1'b0;
    int ignore_n   = 0;
    bit exact_gap  = 1'b0;
    int trig_count = 0;
    bit retry_seen = 1'b0;

    // uart_tx model state
    int         busy_left   = 0;
    bit         pend        = 1'b0;
    bit         in_frame    = 1'b0;
    bit         prev_trig   = 1'b0;
    int         last_fall   = -1;
    bit         ign_pending = 1'b0;
    int         ign_cyc     = 0;
    logic [7:0] ign_data    = 8'h00;
    logic [7:0] cap         = 8'h00;
    logic [7:0] exp_b;

    // Raises tx_bsy the cycle after an accepted trigger, holds it busy_len cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                tx_bsy = 1'b0; pend = 1'b0; busy_left = 0; in_frame = 1'b0;
                prev_trig = 1'b0; last_fall = -1; ign_pending = 1'b0;
                continue;
            end
            if (in_frame) begin
                checks++;
                if (send_data !== cap) begin
                    errors++;
                    $display("FAIL send_data_stable: cycle %0d got %02h, required %02h", cyc, send_data, cap);
                end
            end
            if (pend) begin
                tx_bsy = 1'b1; busy_left = busy_len; pend = 1'b0;
            end else if (tx_bsy && !stall) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_bsy = 1'b0; last_fall = cyc; in_frame = 1'b0;
                end
            end
            if (send_trig) begin
                trig_count++;
                checks++;
                if (prev_trig) begin
                    errors++;
                    $display("FAIL trig_single_cycle: send_trig high two cycles in a row at cycle %0d", cyc);
                end
                if (ignore_n > 0) begin
                    ignore_n--; ign_pending = 1'b1; ign_cyc = cyc; ign_data = send_data;
                end else begin
                    checks++;
                    if (tx_bsy || pend) begin
                        errors++;
                        $display("FAIL trig_while_busy: trigger at cycle %0d, required tx_bsy low", cyc);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_order: unexpected trigger data %02h, required no trigger", send_data);
                    end else begin
                        exp_b = sb.pop_front();
                        if (send_data !== exp_b) begin
                            errors++;
                            $display("FAIL sb_order: got %02h, required %02h", send_data, exp_b);
                        end
                    end
                    if (ign_pending) begin
                        retry_seen = 1'b1; ign_pending = 1'b0;
                        checks++;
                        if (cyc - ign_cyc != TRIG_TIMEOUT) begin
                            errors++;
                            $display("FAIL retry_spacing: got %0d cycles, required %0d", cyc - ign_cyc, TRIG_TIMEOUT);
                        end
                        checks++;
                        if (send_data !== ign_data) begin
                            errors++;
                            $display("FAIL retry_data: got %02h, required %02h", send_data, ign_data);
                        end
                    end
                    if (last_fall >= 0) begin
                        checks++;
                        if (exact_gap ? (cyc - last_fall != GAP_CYCLES + 3) : (cyc - last_fall < GAP_CYCLES + 3)) begin
                            errors++;
                            $display("FAIL trig_gap: got %0d cycles after tx_bsy fall, required %s%0d",
                                     cyc - last_fall, exact_gap ? "" : ">=", GAP_CYCLES + 3);
                        end
                    end
                    cap = send_data; pend = 1'b1; in_frame = 1'b1;
                end
            end
            prev_trig = send_trig;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0; flush = 1'b0;
        busy_len = 91; stall = 1'b0; ignore_n = 0; exact_gap = 1'b0; retry_seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        trig_count = 0;
    endtask

    // Called at a falling edge; returns at the falling edge after the push.
    task automatic push(input logic [7:0] d, input bit acc);
        wr_en = 1'b1; wr_data = d;
        if (acc) sb.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_bsy(input int budget, input string tag);
        int n = 0;
        while (tx_bsy !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (tx_bsy !== 1'b1) begin
            errors++;
            $display("FAIL %s: tx_bsy %b after %0d cycles, required 1", tag, tx_bsy, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(idle === 1'b1 && tx_bsy === 1'b0) && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (!(idle === 1'b1 && tx_bsy === 1'b0)) begin
            errors++;
            $display("FAIL %s: idle %b after %0d cycles, required 1", tag, idle, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (send_trig !== 1'b0)   begin errors++; $display("FAIL rst_trig: got %b, required 0", send_trig); end
        checks++; if (send_data !== 8'h00)  begin errors++; $display("FAIL rst_data: got %02h, required 00", send_data); end
        checks++; if (full !== 1'b0)        begin errors++; $display("FAIL rst_full: got %b, required 0", full); end
        checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL rst_empty: got %b, required 1", empty); end
        checks++; if (count !== 5'd0)       begin errors++; $display("FAIL rst_count: got %0d, required 0", count); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
        checks++; if (idle !== 1'b1)        begin errors++; $display("FAIL rst_idle: got %b, required 1", idle); end
        checks++; if (bytes_sent !== 16'd0) begin errors++; $display("FAIL rst_bytes: got %0d, required 0", bytes_sent); end
        checks++; if (retries !== 8'd0)     begin errors++; $display("FAIL rst_retries: got %0d, required 0", retries); end
    endtask

    task automatic test_single();
        do_reset();
        push(8'hA5, 1'b1);
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d, required 1", count); end
        @(negedge clk);
        checks++; if (send_trig !== 1'b0) begin errors++; $display("FAIL single_trig_c2: got %b, required 0", send_trig); end
        @(negedge clk);
        checks++; if (send_trig !== 1'b1) begin errors++; $display("FAIL single_trig_c3: got %b, required 1", send_trig); end
        checks++; if (send_data !== 8'hA5) begin errors++; $display("FAIL single_data_c3: got %02h, required a5", send_data); end
        @(negedge clk);
        checks++; if (send_trig !== 1'b0) begin errors++; $display("FAIL single_trig_c4: got %b, required 0", send_trig); end
        checks++; if (tx_bsy !== 1'b1) begin errors++; $display("FAIL single_bsy_c4: got %b, required 1", tx_bsy); end
        wait_idle(300, "single_idle");
        checks++; if (bytes_sent !== 16'd1) begin errors++; $display("FAIL single_bytes: got %0d, required 1", bytes_sent); end
        checks++; if (trig_count != 1) begin errors++; $display("FAIL single_trigs: got %0d, required 1", trig_count); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL single_sb: %0d left, required 0", sb.size()); end
    endtask

    // A filler frame held busy keeps the sequencer out of IDLE while the burst lands.
    task automatic test_overflow();
        do_reset();
        busy_len = 20;
        push(8'hEE, 1'b1);
        wait_bsy(20, "ovf_filler_bsy");
        stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(8'(i), i < 16);
            if (i == 15) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full16: got %b, required 1", full); end
                checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count16: got %0d, required 16", count); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b, required 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_after: got %0d, required 16", count); end
        exact_gap = 1'b1;
        stall = 1'b0;
        wait_idle(2000, "ovf_drain");
        exact_gap = 1'b0;
        checks++; if (bytes_sent !== 16'd17) begin errors++; $display("FAIL ovf_bytes: got %0d, required 17", bytes_sent); end
        checks++; if (trig_count != 17) begin errors++; $display("FAIL ovf_trigs: got %0d, required 17", trig_count); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ovf_sb: %0d left, required 0", sb.size()); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_stream();
        do_reset();
        busy_len = 20;
        for (int i = 0; i < 40; i++) begin
            push(8'(i), 1'b1);
            repeat (49) @(negedge clk);
        end
        wait_idle(500, "stream_idle");
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf: got %b, required 0", overflow); end
        checks++; if (bytes_sent !== 16'd40) begin errors++; $display("FAIL stream_bytes: got %0d, required 40", bytes_sent); end
        checks++; if (trig_count != 40) begin errors++; $display("FAIL stream_trigs: got %0d, required 40", trig_count); end
        checks++; if (retries !== 8'd0) begin errors++; $display("FAIL stream_retries: got %0d, required 0", retries); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_sb: %0d left, required 0", sb.size()); end
    endtask

    task automatic test_retry();
        do_reset();
        busy_len = 30;
        ignore_n = 1;
        push(8'h3C, 1'b1);
        wait_idle(300, "retry_idle");
        checks++; if (retry_seen !== 1'b1) begin errors++; $display("FAIL retry_seen: got %b, required 1", retry_seen); end
        checks++; if (retries !== 8'd1) begin errors++; $display("FAIL retry_count: got %0d, required 1", retries); end
        checks++; if (bytes_sent !== 16'd1) begin errors++; $display("FAIL retry_bytes: got %0d, required 1", bytes_sent); end
        checks++; if (trig_count != 2) begin errors++; $display("FAIL retry_trigs: got %0d, required 2", trig_count); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL retry_sb: %0d left, required 0", sb.size()); end
    endtask

    task automatic test_flush();
        do_reset();
        busy_len = 40;
        push(8'h50, 1'b1);
        for (int i = 1; i < 5; i++) push(8'h50 + 8'(i), 1'b0);
        wait_bsy(20, "flush_bsy");
        checks++; if (count !== 5'd4) begin errors++; $display("FAIL flush_pre_count: got %0d, required 4", count); end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        @(negedge clk);
        flush = 1'b0; wr_en = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d, required 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b, required 1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b, required 0", overflow); end
        wait_idle(300, "flush_idle");
        checks++; if (bytes_sent !== 16'd1) begin errors++; $display("FAIL flush_bytes: got %0d, required 1", bytes_sent); end
        repeat (50) @(negedge clk);
        checks++; if (trig_count != 1) begin errors++; $display("FAIL flush_trigs: got %0d, required 1", trig_count); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count_late: got %0d, required 0", count); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL flush_sb: %0d left, required 0", sb.size()); end
    endtask

    task automatic test_mid_reset();
        int t0;
        do_reset();
        for (int i = 0; i < 4; i++) push(8'h61 + 8'(i), 1'b1);
        wait_bsy(20, "midrst_bsy");
        repeat (5) @(negedge clk);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL midrst_pre_count: got %0d, required 3", count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        checks++;
        if ({send_trig, send_data, full, empty, count, overflow, idle, bytes_sent, retries} !==
            {1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL midrst_outputs: got trig=%b data=%02h full=%b empty=%b count=%0d ovf=%b idle=%b sent=%0d retries=%0d, required reset values",
                     send_trig, send_data, full, empty, count, overflow, idle, bytes_sent, retries);
        end
        t0 = trig_count;
        repeat (200) @(negedge clk);
        checks++; if (trig_count != t0) begin errors++; $display("FAIL midrst_trigs: got %0d triggers, required 0", trig_count - t0); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b, required 1", idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_stream();
        test_retry();
        test_flush();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
